neighbourhood_window_streamer: RTL and testbench

Converts a raster-ordered stream of cell states into a stream of per-cell 3×3 neighbourhoods. It sits directly upstream of the 8-input ones counter in the generation-update path. Each output beat carries the centre cell and its 8 neighbour bits, which are fed straight into the counter's `vector_in`. Cells outside the grid read as dead (0); there is no toroidal wrap.

---
 rtl/life_pkg.sv | 50 +++++
 rtl/cell_line_buffer.sv | 47 ++++
 rtl/neighbourhood_window_streamer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_neighbourhood_window_streamer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// ---------------------------------------------------------------------------
// life_pkg
// Shared definitions for the generation-update path of the cellular
// automaton: the neighbour bit positions inside a 3x3 neighbourhood, the
// neighbourhood vector type handed to the ones counter and the rule stage,
// the window streamer FSM encoding, and the grid-edge masking helper.
// ---------------------------------------------------------------------------
package life_pkg;

    // Bit positions of the eight neighbours inside neighbourhood_t.
    localparam int NB_NW = 0;
    localparam int NB_N  = 1;
    localparam int NB_NE = 2;
    localparam int NB_W  = 3;
    localparam int NB_E  = 4;
    localparam int NB_SW = 5;
    localparam int NB_S  = 6;
    localparam int NB_SE = 7;

    typedef logic [7:0] neighbourhood_t;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } stream_state_e;

    // Clears every neighbour that lies outside the grid. The window register
    // holds stale or wrapped-around data at the edges, so all four sides are
    // masked from the emit position rather than trusting the buffered bits.
    function automatic neighbourhood_t mask_window(
        input neighbourhood_t raw,
        input logic           at_west,
        input logic           at_east,
        input logic           at_north,
        input logic           at_south
    );
        neighbourhood_t m;
        m[NB_NW] = raw[NB_NW] & ~at_west & ~at_north;
        m[NB_N]  = raw[NB_N]             & ~at_north;
        m[NB_NE] = raw[NB_NE] & ~at_east & ~at_north;
        m[NB_W]  = raw[NB_W]  & ~at_west;
        m[NB_E]  = raw[NB_E]  & ~at_east;
        m[NB_SW] = raw[NB_SW] & ~at_west & ~at_south;
        m[NB_S]  = raw[NB_S]             & ~at_south;
        m[NB_SE] = raw[NB_SE] & ~at_east & ~at_south;
        return m;
    endfunction

endpackage

// File: rtl/cell_line_buffer.sv
// ---------------------------------------------------------------------------
// cell_line_buffer
// DEPTH-deep, 1-bit shift register holding one grid row of cell states.
// While shift_en is high a new bit enters at din; dout always shows the bit
// that entered DEPTH shifts ago, i.e. the cell one row above the one at din.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset, clears the row to dead cells
//   shift_en - advance the row by one cell
//   din      - cell state entering the row
//   dout     - cell state leaving the row (DEPTH shifts old)
// ---------------------------------------------------------------------------
module cell_line_buffer #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // Next row contents: shift one cell in when enabled, otherwise hold.
    always_comb begin
        if (shift_en) begin
            sr_d = {sr_q[DEPTH-2:0], din};
        end else begin
            sr_d = sr_q;
        end
    end

    // Row storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= {DEPTH{1'b0}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/neighbourhood_window_streamer.sv
// ---------------------------------------------------------------------------
// neighbourhood_window_streamer
// Turns a raster-ordered stream of cell states into a stream of 3x3
// neighbourhoods, one output beat per cell, in the same raster order.
// Off-grid neighbours read as dead; there is no wrap-around.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-high reset, abandons any frame
//   cell_in    - current-generation cell state (input stream)
//   in_valid   - cell_in is valid
//   in_ready   - cell_in is accepted this cycle
//   window_out - eight neighbour bits, positions from life_pkg NB_*
//   center_out - state of the cell being emitted
//   out_last   - marks the bottom-right cell of the frame
//   out_valid  - output beat valid
//   out_ready  - downstream accepts the beat
//
// Data path: the incoming cell is the SE neighbour of the cell being
// emitted. Two chained line buffers deliver the cells one and two rows
// above it, and those three bits form the new east column of the window.
// The output register is loaded from the post-shift window, giving the
// one-cycle registered latency after the enabling input beat.
// ---------------------------------------------------------------------------
module neighbourhood_window_streamer
    import life_pkg::*;
#(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cell_in,
    input  logic           in_valid,
    output logic           in_ready,
    output neighbourhood_t window_out,
    output logic           center_out,
    output logic           out_last,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int FW = $clog2(GRID_W + 1);

    localparam logic [XW-1:0] X_LAST    = XW'(GRID_W - 1);
    localparam logic [XW-1:0] X_PRE     = XW'(GRID_W - 2);
    localparam logic [YW-1:0] Y_LAST    = YW'(GRID_H - 1);
    localparam logic [YW-1:0] Y_PRE     = YW'(GRID_H - 2);
    localparam logic [FW-1:0] FILL_LAST = FW'(GRID_W);

    stream_state_e  state_q, state_d;
    logic [FW-1:0]  fill_cnt_q, fill_cnt_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    // Window rows: bit 2 = west column, bit 1 = centre column, bit 0 = east.
    logic [2:0]     win_top_q, win_top_d;
    logic [2:0]     win_mid_q, win_mid_d;
    logic [2:0]     win_bot_q, win_bot_d;
    logic           out_valid_q, out_valid_d;
    neighbourhood_t window_q, window_d;
    logic           center_q, center_d;
    logic           last_q, last_d;

    logic           in_ready_s;
    logic           shift_s;
    logic           load_s;
    logic           take_s;
    logic           shift_din_s;
    logic           lb0_out_s;
    logic           lb1_out_s;
    logic           at_west_s;
    logic           at_east_s;
    logic           at_north_s;
    logic           at_south_s;
    neighbourhood_t raw_s;

    // Row y (one row above the incoming cell).
    cell_line_buffer #(.DEPTH(GRID_W)) u_line_cur (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_s),
        .din      (shift_din_s),
        .dout     (lb0_out_s)
    );

    // Row y-1 (two rows above the incoming cell).
    cell_line_buffer #(.DEPTH(GRID_W)) u_line_prev (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_s),
        .din      (lb0_out_s),
        .dout     (lb1_out_s)
    );

    assign take_s     = out_valid_q & out_ready;
    assign at_west_s  = (x_q == {XW{1'b0}});
    assign at_east_s  = (x_q == X_LAST);
    assign at_north_s = (y_q == {YW{1'b0}});
    assign at_south_s = (y_q == Y_LAST);

    // Handshake decode: when the pipeline advances and when a beat is loaded.
    // During FLUSH dead cells are injected and loading stops once the last
    // beat sits in the output register.
    always_comb begin
        in_ready_s  = 1'b0;
        shift_s     = 1'b0;
        load_s      = 1'b0;
        shift_din_s = cell_in;
        case (state_q)
            ST_FILL: begin
                in_ready_s = 1'b1;
                shift_s    = in_valid;
            end
            ST_RUN: begin
                in_ready_s = ~out_valid_q | out_ready;
                shift_s    = in_valid & in_ready_s;
                load_s     = shift_s;
            end
            ST_FLUSH: begin
                shift_din_s = 1'b0;
                load_s      = (~out_valid_q | out_ready) & ~(out_valid_q & last_q);
                shift_s     = load_s;
            end
            default: begin
                shift_din_s = 1'b0;
            end
        endcase
    end

    // Window shift: new east column is {row y-1, row y, incoming cell}.
    always_comb begin
        if (shift_s) begin
            win_top_d = {win_top_q[1:0], lb1_out_s};
            win_mid_d = {win_mid_q[1:0], lb0_out_s};
            win_bot_d = {win_bot_q[1:0], shift_din_s};
        end else begin
            win_top_d = win_top_q;
            win_mid_d = win_mid_q;
            win_bot_d = win_bot_q;
        end
    end

    // Raw neighbourhood taken from the post-shift window.
    always_comb begin
        raw_s        = 8'h00;
        raw_s[NB_NW] = win_top_d[2];
        raw_s[NB_N]  = win_top_d[1];
        raw_s[NB_NE] = win_top_d[0];
        raw_s[NB_W]  = win_mid_d[2];
        raw_s[NB_E]  = win_mid_d[0];
        raw_s[NB_SW] = win_bot_d[2];
        raw_s[NB_S]  = win_bot_d[1];
        raw_s[NB_SE] = win_bot_d[0];
    end

    // Output register: load a new beat, retire a taken beat, or hold.
    always_comb begin
        out_valid_d = out_valid_q;
        window_d    = window_q;
        center_d    = center_q;
        last_d      = last_q;
        if (load_s) begin
            out_valid_d = 1'b1;
            window_d    = mask_window(raw_s, at_west_s, at_east_s, at_north_s, at_south_s);
            center_d    = win_mid_d[1];
            last_d      = at_east_s & at_south_s;
        end else if (take_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Emit position counters advance with every loaded beat and wrap per frame.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (load_s) begin
            if (at_east_s) begin
                x_d = {XW{1'b0}};
                if (at_south_s) begin
                    y_d = {YW{1'b0}};
                end else begin
                    y_d = y_q + YW'(1);
                end
            end else begin
                x_d = x_q + XW'(1);
            end
        end else begin
            x_d = x_q;
        end
    end

    // FSM next state. The final input of the frame is the one that loads the
    // beat at (GRID_W-2, GRID_H-2), so RUN ends on that accept.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        case (state_q)
            ST_FILL: begin
                if (shift_s) begin
                    if (fill_cnt_q == FILL_LAST) begin
                        fill_cnt_d = {FW{1'b0}};
                        state_d    = ST_RUN;
                    end else begin
                        fill_cnt_d = fill_cnt_q + FW'(1);
                    end
                end else begin
                    fill_cnt_d = fill_cnt_q;
                end
            end
            ST_RUN: begin
                if (shift_s && (x_q == X_PRE) && (y_q == Y_PRE)) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (take_s && last_q) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d    = ST_FILL;
                fill_cnt_d = {FW{1'b0}};
            end
        endcase
    end

    // All state of the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FILL;
            fill_cnt_q  <= {FW{1'b0}};
            x_q         <= {XW{1'b0}};
            y_q         <= {YW{1'b0}};
            win_top_q   <= 3'b000;
            win_mid_q   <= 3'b000;
            win_bot_q   <= 3'b000;
            out_valid_q <= 1'b0;
            window_q    <= 8'h00;
            center_q    <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            win_top_q   <= win_top_d;
            win_mid_q   <= win_mid_d;
            win_bot_q   <= win_bot_d;
            out_valid_q <= out_valid_d;
            window_q    <= window_d;
            center_q    <= center_d;
            last_q      <= last_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_q;
    assign window_out = window_q;
    assign center_out = center_q;
    assign out_last   = last_q;

endmodule

// File: tb/tb_neighbourhood_window_streamer.sv
// ---------------------------------------------------------------------------
// tb_neighbourhood_window_streamer
// Two instances: 4x4 (directed frames, reset and flush-stall cases) and 8x5
// (random handshakes over back-to-back frames). Every taken beat is compared
// with a reference that looks up the 8 neighbours directly in the frame
// array; directed frames are additionally checked against a constant table.
// ---------------------------------------------------------------------------
module tb_neighbourhood_window_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       cell_in_s    [2];
    logic       in_valid_s   [2];
    logic       in_ready_s   [2];
    logic [7:0] window_out_s [2];
    logic       center_out_s [2];
    logic       out_last_s   [2];
    logic       out_valid_s  [2];
    logic       out_ready_s  [2];

    int checks = 0;
    int errors = 0;

    logic       grid    [0:63];
    logic [7:0] got_win [0:63];
    logic       got_ctr [0:63];

    typedef struct {
        int         pat;
        int         k;
        logic [7:0] win;
        logic       ctr;
    } vec_t;
    vec_t vecs [$];

    neighbourhood_window_streamer #(.GRID_W(4), .GRID_H(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .cell_in    (cell_in_s[0]),
        .in_valid   (in_valid_s[0]),
        .in_ready   (in_ready_s[0]),
        .window_out (window_out_s[0]),
        .center_out (center_out_s[0]),
        .out_last   (out_last_s[0]),
        .out_valid  (out_valid_s[0]),
        .out_ready  (out_ready_s[0])
    );

    neighbourhood_window_streamer #(.GRID_W(8), .GRID_H(5)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .cell_in    (cell_in_s[1]),
        .in_valid   (in_valid_s[1]),
        .in_ready   (in_ready_s[1]),
        .window_out (window_out_s[1]),
        .center_out (center_out_s[1]),
        .out_last   (out_last_s[1]),
        .out_valid  (out_valid_s[1]),
        .out_ready  (out_ready_s[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int grid_w(input int d);
        return (d == 0) ? 4 : 8;
    endfunction

    function automatic int grid_h(input int d);
        return (d == 0) ? 4 : 5;
    endfunction

    // Reference beat {centre, neighbours} for raster index k of a w x h frame.
    function automatic logic [8:0] ref_beat(input int w, input int h, input int k);
        int         dx [8];
        int         dy [8];
        int         x, y, nx, ny;
        logic [7:0] nb;
        dx = '{-1, 0, 1, -1, 1, -1, 0, 1};
        dy = '{-1, -1, -1, 0, 0, 1, 1, 1};
        x  = k % w;
        y  = k / w;
        nb = 8'h00;
        for (int i = 0; i < 8; i++) begin
            nx = x + dx[i];
            ny = y + dy[i];
            if (nx >= 0 && nx < w && ny >= 0 && ny < h) nb[i] = grid[ny * w + nx];
        end
        return {grid[k], nb};
    endfunction

    // Streams grid[] through instance d with the given valid/ready
    // probabilities. flush_hold stalls out_ready once all inputs are in;
    // abort_after > 0 returns at that cycle's falling edge, mid-frame.
    task automatic run_frame(input int d, input int vpct, input int rpct,
                             input int flush_hold, input int abort_after);
        int         w, h, n, in_idx, out_idx, cyc, hold_left;
        bit         seen_valid, prev_stall;
        logic       iv, ordy, ov, ir, ctr, lst, p_ctr, p_lst;
        logic [7:0] win, p_win;
        logic [8:0] exp;
        w = grid_w(d);
        h = grid_h(d);
        n = w * h;
        in_idx = 0; out_idx = 0; cyc = 0; hold_left = flush_hold;
        seen_valid = 1'b0; prev_stall = 1'b0;
        p_win = 8'h00; p_ctr = 1'b0; p_lst = 1'b0;
        for (int k = 0; k < 64; k++) begin
            got_win[k] = 8'hxx;
            got_ctr[k] = 1'bx;
        end
        while (out_idx < n) begin
            @(negedge clk);
            if (abort_after > 0 && cyc == abort_after) return;
            if (cyc == 4000) begin
                check($sformatf("frame_timeout d%0d beats", d), 32'(out_idx), 32'(n));
                break;
            end
            iv = (in_idx < n) && (int'($urandom_range(99)) < vpct);
            if (in_idx == n && hold_left > 0) begin
                ordy = 1'b0;
                hold_left--;
            end else begin
                ordy = (int'($urandom_range(99)) < rpct);
            end
            in_valid_s[d]  = iv;
            cell_in_s[d]   = iv ? grid[in_idx] : 1'($urandom);
            out_ready_s[d] = ordy;
            #1;
            ov  = out_valid_s[d];
            ir  = in_ready_s[d];
            win = window_out_s[d];
            ctr = center_out_s[d];
            lst = out_last_s[d];
            if (prev_stall) begin
                check($sformatf("stall_valid d%0d k%0d", d, out_idx), 32'(ov), 32'd1);
                check($sformatf("stall_window d%0d k%0d", d, out_idx), 32'(win), 32'(p_win));
                check($sformatf("stall_center d%0d k%0d", d, out_idx), 32'(ctr), 32'(p_ctr));
                check($sformatf("stall_last d%0d k%0d", d, out_idx), 32'(lst), 32'(p_lst));
            end
            if (ov && !seen_valid) begin
                seen_valid = 1'b1;
                check($sformatf("first_valid_accepts d%0d", d), 32'(in_idx), 32'(w + 2));
            end
            if (in_idx < w + 1) check($sformatf("in_ready_fill d%0d", d), 32'(ir), 32'd1);
            if (in_idx == n)    check($sformatf("in_ready_flush d%0d", d), 32'(ir), 32'd0);
            if (iv && ir) in_idx++;
            if (ov && ordy) begin
                exp = ref_beat(w, h, out_idx);
                check($sformatf("window d%0d k%0d", d, out_idx), 32'(win), 32'(exp[7:0]));
                check($sformatf("center d%0d k%0d", d, out_idx), 32'(ctr), 32'(exp[8]));
                check($sformatf("last d%0d k%0d", d, out_idx), 32'(lst), 32'(out_idx == n - 1));
                got_win[out_idx] = win;
                got_ctr[out_idx] = ctr;
                out_idx++;
            end
            prev_stall = ov && !ordy;
            p_win = win; p_ctr = ctr; p_lst = lst;
            cyc++;
        end
        @(negedge clk);
        in_valid_s[d]  = 1'b0;
        out_ready_s[d] = 1'b0;
        #1;
        check($sformatf("idle_valid d%0d", d), 32'(out_valid_s[d]), 32'd0);
        check($sformatf("idle_in_ready d%0d", d), 32'(in_ready_s[d]), 32'd1);
    endtask

    task automatic check_reset_state(input int d);
        check($sformatf("rst_valid d%0d", d), 32'(out_valid_s[d]), 32'd0);
        check($sformatf("rst_window d%0d", d), 32'(window_out_s[d]), 32'd0);
        check($sformatf("rst_center d%0d", d), 32'(center_out_s[d]), 32'd0);
        check($sformatf("rst_last d%0d", d), 32'(out_last_s[d]), 32'd0);
        check($sformatf("rst_in_ready d%0d", d), 32'(in_ready_s[d]), 32'd1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            cell_in_s[d]   = 1'b0;
            in_valid_s[d]  = 1'b0;
            out_ready_s[d] = 1'b0;
        end
        // pattern 0: all dead
        vecs.push_back('{0, 0,  8'h00, 1'b0});
        vecs.push_back('{0, 15, 8'h00, 1'b0});
        // pattern 1: only (1,1) alive
        vecs.push_back('{1, 0,  8'h80, 1'b0});
        vecs.push_back('{1, 1,  8'h40, 1'b0});
        vecs.push_back('{1, 2,  8'h20, 1'b0});
        vecs.push_back('{1, 4,  8'h10, 1'b0});
        vecs.push_back('{1, 5,  8'h00, 1'b1});
        vecs.push_back('{1, 6,  8'h08, 1'b0});
        vecs.push_back('{1, 8,  8'h04, 1'b0});
        vecs.push_back('{1, 9,  8'h02, 1'b0});
        vecs.push_back('{1, 10, 8'h01, 1'b0});
        vecs.push_back('{1, 15, 8'h00, 1'b0});
        // pattern 2: all alive; corners E|S|SE, W|SW|S, N|NE|E, NW|N|W
        vecs.push_back('{2, 0,  8'hD0, 1'b1});
        vecs.push_back('{2, 3,  8'h68, 1'b1});
        vecs.push_back('{2, 12, 8'h16, 1'b1});
        vecs.push_back('{2, 15, 8'h0B, 1'b1});
        vecs.push_back('{2, 5,  8'hFF, 1'b1});
        vecs.push_back('{2, 10, 8'hFF, 1'b1});
        vecs.push_back('{2, 7,  8'h6B, 1'b1});
        vecs.push_back('{2, 4,  8'hD6, 1'b1});

        rst = 1'b0;
        #2 rst = 1'b1;
        #10;
        check_reset_state(0);
        check_reset_state(1);
        @(negedge clk);
        rst = 1'b0;

        // Directed 4x4 frames with continuous handshakes, then table checks.
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 16; k++) grid[k] = (p == 2) ? 1'b1 : ((p == 1) && (k == 5));
            run_frame(0, 100, 100, 0, 0);
            foreach (vecs[i]) begin
                if (vecs[i].pat == p) begin
                    check($sformatf("table p%0d k%0d window", p, vecs[i].k),
                          32'(got_win[vecs[i].k]), 32'(vecs[i].win));
                    check($sformatf("table p%0d k%0d center", p, vecs[i].k),
                          32'(got_ctr[vecs[i].k]), 32'(vecs[i].ctr));
                end
            end
        end

        // Three 8x5 frames with random valid/ready.
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 40; k++) grid[k] = 1'($urandom);
            run_frame(1, 50, 50, 0, 0);
        end

        // Reset seven cycles into a frame, then a fresh frame.
        for (int k = 0; k < 16; k++) grid[k] = 1'($urandom);
        grid[0] = 1'b1; grid[1] = 1'b1; grid[4] = 1'b1; grid[5] = 1'b1;
        run_frame(0, 100, 100, 0, 7);
        check("pre_reset_valid", 32'(out_valid_s[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_reset_state(0);
        @(negedge clk);
        rst = 1'b0;
        in_valid_s[0]  = 1'b0;
        out_ready_s[0] = 1'b0;
        for (int k = 0; k < 16; k++) grid[k] = 1'($urandom);
        run_frame(0, 70, 70, 0, 0);

        // out_ready held low for 10 cycles once FLUSH is entered.
        for (int k = 0; k < 16; k++) grid[k] = 1'($urandom);
        run_frame(0, 100, 100, 10, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
